// File: rtl/mem_bank_pkg.sv
// rtl/mem_bank_pkg.sv - shared FSM state type and sweep pipeline constants for mem_bank_ctrl
package mem_bank_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam int PIPE_LAT  = 2;
    localparam int DRAIN_LEN = PIPE_LAT;

endpackage

// File: rtl/mem_bank_sp.sv
// rtl/mem_bank_sp.sv - single-port synchronous RAM with registered read-first output
module mem_bank_sp #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= din;
        end
        dout <= mem[addr];
    end

endmodule

// File: rtl/mem_bank_ctrl.sv
// rtl/mem_bank_ctrl.sv - button-driven two-bank memory controller with a half-word sum sweep
// Define MEM_BANK_CTRL_MULT_EN to make the sweep compute hi*lo instead of hi+lo.
module mem_bank_ctrl
    import mem_bank_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] sw_data,
    input  logic              inc_btn,
    input  logic              dec_btn,
    input  logic              sel_in_btn,
    input  logic              sel_out_btn,
    input  logic              exec_btn,
    output logic [DATA_W-1:0] disp_data,
    output logic [ADDR_W-1:0] addr,
    output logic              bank_sel,
    output logic              busy,
    output logic              done
);

    localparam int HALF = DATA_W / 2;
    localparam logic [ADDR_W-1:0] ADDR_MAX = ADDR_W'(2**ADDR_W - 1);
    localparam logic [1:0] DRAIN_LAST = 2'(DRAIN_LEN - 1);

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] idx, idx_nxt, idx1, idx2;
    logic [1:0]        drain_cnt, drain_cnt_nxt;
    logic              done_nxt;
    logic              v1, v2, rd_ok, armed;
    logic [4:0]        btn, btn_q, btn_e;
    logic              inc_e, dec_e, sel_in_e, sel_out_e, exec_e;
    logic              addr_clr, wr_in, start;
    logic [ADDR_W-1:0] addr_nxt, in_addr, out_addr;
    logic              bank_sel_nxt;
    logic [DATA_W-1:0] in_q, out_q, op_res, res;
    logic [HALF-1:0]   hi, lo;

    assign btn = {exec_btn, sel_out_btn, sel_in_btn, dec_btn, inc_btn};

    // History is captured the first cycle after reset without acting, so held buttons make no edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_q <= '0;
            armed <= 1'b0;
        end else begin
            btn_q <= btn;
            armed <= 1'b1;
        end
    end

    assign btn_e = (armed && state == IDLE) ? (btn & ~btn_q) : '0;
    assign {exec_e, sel_out_e, sel_in_e, dec_e, inc_e} = btn_e;

    assign addr_clr = (inc_e & dec_btn) | (dec_e & inc_btn);
    assign wr_in    = (sel_in_e & exec_btn) | (exec_e & sel_in_btn);
    assign start    = (sel_out_e & exec_btn) | (exec_e & sel_out_btn);
    assign busy     = (state != IDLE);

    always_comb begin
        addr_nxt = addr;
        if (addr_clr) begin
            addr_nxt = '0;
        end else if (inc_e && addr != ADDR_MAX) begin
            addr_nxt = addr + 1'b1;
        end else if (dec_e && addr != '0) begin
            addr_nxt = addr - 1'b1;
        end
    end

    always_comb begin
        bank_sel_nxt = bank_sel;
        if (sel_out_e) begin
            bank_sel_nxt = 1'b0;
        end else if (sel_in_e) begin
            bank_sel_nxt = 1'b1;
        end
    end

    always_comb begin
        state_nxt     = state;
        idx_nxt       = idx;
        drain_cnt_nxt = drain_cnt;
        done_nxt      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = SWEEP;
                    idx_nxt   = '0;
                end
            end
            SWEEP: begin
                idx_nxt = idx + 1'b1;
                if (idx == ADDR_MAX) begin
                    state_nxt     = DRAIN;
                    drain_cnt_nxt = '0;
                end
            end
            DRAIN: begin
                drain_cnt_nxt = drain_cnt + 1'b1;
                if (drain_cnt == DRAIN_LAST) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            idx       <= '0;
            drain_cnt <= '0;
            done      <= 1'b0;
            addr      <= '0;
            bank_sel  <= 1'b1;
        end else begin
            state     <= state_nxt;
            idx       <= idx_nxt;
            drain_cnt <= drain_cnt_nxt;
            done      <= done_nxt;
            addr      <= addr_nxt;
            bank_sel  <= bank_sel_nxt;
        end
    end

    assign hi = in_q[DATA_W-1:HALF];
    assign lo = in_q[HALF-1:0];

`ifdef MEM_BANK_CTRL_MULT_EN
    assign op_res = DATA_W'(hi) * DATA_W'(lo);
`else
    assign op_res = DATA_W'({1'b0, hi} + {1'b0, lo});
`endif

    // Read in SWEEP, operate on the RAM output next cycle, write out_bank the cycle after.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1   <= 1'b0;
            v2   <= 1'b0;
            idx1 <= '0;
            idx2 <= '0;
            res  <= '0;
        end else begin
            v1   <= (state == SWEEP);
            v2   <= v1;
            idx1 <= idx;
            idx2 <= idx1;
            res  <= op_res;
        end
    end

    assign in_addr  = (state == SWEEP) ? idx : (wr_in ? addr : addr_nxt);
    assign out_addr = v2 ? idx2 : addr_nxt;

    mem_bank_sp #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_in_bank (
        .clk  (clk),
        .we   (wr_in),
        .addr (in_addr),
        .din  (sw_data),
        .dout (in_q)
    );

    mem_bank_sp #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_out_bank (
        .clk  (clk),
        .we   (v2),
        .addr (out_addr),
        .din  (res),
        .dout (out_q)
    );

    // RAM outputs only reflect the manual address once a full idle cycle has elapsed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ok     <= 1'b0;
            disp_data <= '0;
        end else begin
            rd_ok <= (state == IDLE);
            if (rd_ok) begin
                disp_data <= bank_sel ? in_q : out_q;
            end
        end
    end

endmodule

// File: tb/tb_mem_bank_ctrl.sv
// tb/tb_mem_bank_ctrl.sv - directed scoreboard bench for mem_bank_ctrl
module tb_mem_bank_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] sw_data;
    logic [4:0]  btns;
    logic [15:0] disp_data;
    logic [3:0]  addr;
    logic        bank_sel, busy, done;

    int          n_chk = 0;
    int          n_fail = 0;
    int          busy_cnt, done_cnt;
    logic [15:0] sb[$];
    logic [15:0] exp_v;

    always #5 clk = ~clk;

    mem_bank_ctrl #(.DATA_W(16), .ADDR_W(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .sw_data     (sw_data),
        .inc_btn     (btns[0]),
        .dec_btn     (btns[1]),
        .sel_in_btn  (btns[2]),
        .sel_out_btn (btns[3]),
        .exec_btn    (btns[4]),
        .disp_data   (disp_data),
        .addr        (addr),
        .bank_sel    (bank_sel),
        .busy        (busy),
        .done        (done)
    );

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [4:0] m);
        btns = m;
        tick(1);
        btns = '0;
        tick(1);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] op(input logic [7:0] h, input logic [7:0] l);
`ifdef MEM_BANK_CTRL_MULT_EN
        return 16'(h) * 16'(l);
`else
        return 16'({1'b0, h} + {1'b0, l});
`endif
    endfunction

    initial begin
        rst_n   = 1'b0;
        sw_data = '0;
        btns    = 5'b00001;
        tick(2);
        chk("rst_addr", 32'(addr), 32'd0);
        chk("rst_bank_sel", 32'(bank_sel), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_disp", 32'(disp_data), 32'd0);
        rst_n = 1'b1;
        tick(3);
        chk("held_inc_no_edge", 32'(addr), 32'd0);
        btns = '0;
        tick(1);

        repeat (3) press(5'b00001);
        press(5'b00010);
        chk("addr_3inc_1dec", 32'(addr), 32'd2);
        btns = 5'b00001;
        tick(5);
        btns = '0;
        tick(1);
        chk("long_inc_once", 32'(addr), 32'd3);
        repeat (20) press(5'b00001);
        chk("addr_saturate", 32'(addr), 32'd15);
        press(5'b00011);
        chk("addr_inc_dec_clear", 32'(addr), 32'd0);
        press(5'b00010);
        chk("addr_dec_at_0", 32'(addr), 32'd0);

        repeat (5) press(5'b00001);
        chk("addr_5", 32'(addr), 32'd5);
        sw_data = 16'h0304;
        sb.push_back(16'h0304);
        sb.push_back(16'h0304);
        btns = 5'b10100;
        tick(1);
        sw_data = 16'hBEEF;
        tick(2);
        exp_v = sb.pop_front();
        chk("write_visible", 32'(disp_data), 32'(exp_v));
        tick(47);
        btns = '0;
        tick(3);
        exp_v = sb.pop_front();
        chk("write_once", 32'(disp_data), 32'(exp_v));

        press(5'b00011);
        for (int i = 0; i < 16; i++) begin
            sw_data = {i[7:0], 8'hFF};
            press(5'b10100);
            press(5'b00001);
        end
        tick(3);
        chk("in_bank_15_disp", 32'(disp_data), 32'h0FFF);

        for (int i = 15; i >= 0; i--) sb.push_back(op(i[7:0], 8'hFF));
        busy_cnt = 0;
        done_cnt = 0;
        btns = 5'b11000;
        for (int c = 0; c < 40; c++) begin
            tick(1);
            busy_cnt += int'(busy);
            done_cnt += int'(done);
            case (c)
                0: btns = '0;
                4: begin sw_data = 16'hAAAA; btns = 5'b10111; end
                5: btns = '0;
                7: btns = 5'b11000;
                8: btns = '0;
                default: ;
            endcase
        end
        chk("sweep_busy_cycles", 32'(busy_cnt), 32'd18);
        chk("sweep_done_pulses", 32'(done_cnt), 32'd1);
        chk("addr_held_in_sweep", 32'(addr), 32'd15);
        chk("bank_sel_held_in_sweep", 32'(bank_sel), 32'd0);

        for (int i = 15; i >= 0; i--) begin
            tick(3);
            if (sb.size() == 0) begin
                chk("scoreboard_empty", 32'd1, 32'd0);
            end else begin
                exp_v = sb.pop_front();
                chk($sformatf("out_bank[%0d]", i), 32'(disp_data), 32'(exp_v));
            end
            press(5'b00010);
        end
        chk("addr_after_readback", 32'(addr), 32'd0);

        press(5'b00100);
        tick(2);
        chk("sel_in_bank_sel", 32'(bank_sel), 32'd1);
        chk("in_bank_0_disp", 32'(disp_data), 32'h00FF);
        press(5'b01100);
        chk("sel_out_wins", 32'(bank_sel), 32'd0);

        press(5'b00001);
        press(5'b00001);
        btns = 5'b11000;
        tick(1);
        btns = '0;
        tick(6);
        chk("busy_before_abort", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_addr", 32'(addr), 32'd0);
        chk("abort_bank_sel", 32'(bank_sel), 32'd1);
        tick(2);
        rst_n = 1'b1;
        busy_cnt = 0;
        done_cnt = 0;
        for (int c = 0; c < 25; c++) begin
            tick(1);
            busy_cnt += int'(busy);
            done_cnt += int'(done);
        end
        chk("abort_no_done", 32'(done_cnt), 32'd0);
        chk("abort_stays_idle", 32'(busy_cnt), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
